// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: WB-stage write, MDU result, RF write port and ID hazard lookup.
// slave = arbiter side, master = surrounding pipeline / testbench side.
interface wb_port_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [4:0]    WB_reg_write_address_in;
   logic [31:0]   WB_reg_write_data_in;
   logic          WB_ctrl_reg_write_in;
   logic          MDU_valid_in;
   logic [4:0]    MDU_rd_in;
   logic [31:0]   MDU_data_in;
   logic          MDU_ready_out;
   logic          RF_we_out;
   logic [4:0]    RF_addr_out;
   logic [31:0]   RF_data_out;
   logic          ARB_stall_out;
   logic [4:0]    ID_rs_in;
   logic [4:0]    ID_rt_in;
   logic          ID_rs_busy_out;
   logic          ID_rt_busy_out;
   logic [CW-1:0] ARB_pend_count_out;

   modport slave (
      input  WB_reg_write_address_in, WB_reg_write_data_in, WB_ctrl_reg_write_in,
      input  MDU_valid_in, MDU_rd_in, MDU_data_in,
      input  ID_rs_in, ID_rt_in,
      output MDU_ready_out, RF_we_out, RF_addr_out, RF_data_out, ARB_stall_out,
      output ID_rs_busy_out, ID_rt_busy_out, ARB_pend_count_out
   );

   modport master (
      output WB_reg_write_address_in, WB_reg_write_data_in, WB_ctrl_reg_write_in,
      output MDU_valid_in, MDU_rd_in, MDU_data_in,
      output ID_rs_in, ID_rt_in,
      input  MDU_ready_out, RF_we_out, RF_addr_out, RF_data_out, ARB_stall_out,
      input  ID_rs_busy_out, ID_rt_busy_out, ARB_pend_count_out
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, MDU results queue and drain into idle
// cycles, starvation forces a stalled drain. Optional WB_ARB_BYPASS_EN lets a lone MDU result skip the queue.
module wb_port_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input logic              clk_in,
   input logic              rst_in,
   wb_port_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [4:0]    fifo_rd_r   [DEPTH];
   logic [31:0]   fifo_data_r [DEPTH];
   logic [PW-1:0] rd_ptr_r, wr_ptr_r;
   logic [CW-1:0] count_r, count_s;
   logic [SW-1:0] starve_r, starve_s;

   logic          rf_we_r, rf_we_s;
   logic [4:0]    rf_addr_r, rf_addr_s;
   logic [31:0]   rf_data_r, rf_data_s;
   logic          from_mdu_r, from_mdu_s;
   logic          stall_r, stall_s;

   logic          wb_req_s, ready_s, push_s, enq_s, bypass_s;
   logic          wb_grant_s, pop_s;
   logic [PW-1:0] off_s;
   logic          rs_hit_s, rt_hit_s;

   // Request decode: r0 targets are dropped, readiness depends only on occupancy.
   always_comb begin
      wb_req_s = bus.WB_ctrl_reg_write_in && (bus.WB_reg_write_address_in != 5'd0);
      ready_s  = (count_r < CW'(DEPTH));
      push_s   = bus.MDU_valid_in && ready_s && (bus.MDU_rd_in != 5'd0);
`ifdef WB_ARB_BYPASS_EN
      bypass_s = push_s && (count_r == CW'(0)) && !wb_req_s && (state_r != DRAIN);
`else
      bypass_s = 1'b0;
`endif
      enq_s    = push_s && !bypass_s;
   end

   // Port grant and the RF write word to be registered this cycle.
   always_comb begin
      wb_grant_s = 1'b0;
      pop_s      = 1'b0;
      rf_we_s    = 1'b0;
      rf_addr_s  = 5'd0;
      rf_data_s  = 32'd0;
      from_mdu_s = 1'b0;
      case (state_r)
         DRAIN: begin
            if (count_r != CW'(0)) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         default: begin
            if (wb_req_s) begin
               wb_grant_s = 1'b1;
            end else if (count_r != CW'(0)) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
      endcase

      if (wb_grant_s) begin
         rf_we_s   = 1'b1;
         rf_addr_s = bus.WB_reg_write_address_in;
         rf_data_s = bus.WB_reg_write_data_in;
      end else if (pop_s) begin
         rf_we_s    = 1'b1;
         rf_addr_s  = fifo_rd_r[rd_ptr_r];
         rf_data_s  = fifo_data_r[rd_ptr_r];
         from_mdu_s = 1'b1;
      end else if (bypass_s) begin
         rf_we_s    = 1'b1;
         rf_addr_s  = bus.MDU_rd_in;
         rf_data_s  = bus.MDU_data_in;
         from_mdu_s = 1'b1;
      end else begin
         rf_we_s = 1'b0;
      end
   end

   // Next state, occupancy and starvation counter; the stall mirrors the DRAIN state.
   always_comb begin
      count_s  = count_r + CW'(enq_s) - CW'(pop_s);
      state_s  = state_r;
      starve_s = starve_r;
      case (state_r)
         IDLE: begin
            starve_s = SW'(0);
            if (enq_s) begin
               state_s = PEND;
            end else begin
               state_s = IDLE;
            end
         end
         PEND: begin
            if (count_s == CW'(0)) begin
               state_s  = IDLE;
               starve_s = SW'(0);
            end else if (wb_grant_s && (starve_r == SW'(STARVE_MAX - 1))) begin
               state_s  = DRAIN;
               starve_s = SW'(0);
            end else if (wb_grant_s) begin
               starve_s = starve_r + SW'(1);
            end else if (pop_s) begin
               starve_s = SW'(0);
            end else begin
               starve_s = starve_r;
            end
         end
         DRAIN: begin
            starve_s = SW'(0);
            if (count_s == CW'(0)) begin
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s  = IDLE;
            starve_s = SW'(0);
         end
      endcase
      stall_s = (state_s == DRAIN);
   end

   // Control state registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r  <= IDLE;
         count_r  <= CW'(0);
         starve_r <= SW'(0);
         stall_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         starve_r <= starve_s;
         stall_r  <= stall_s;
      end
   end

   // Registered RF write port.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rf_we_r    <= 1'b0;
         rf_addr_r  <= 5'd0;
         rf_data_r  <= 32'd0;
         from_mdu_r <= 1'b0;
      end else begin
         rf_we_r    <= rf_we_s;
         rf_addr_r  <= rf_addr_s;
         rf_data_r  <= rf_data_s;
         from_mdu_r <= from_mdu_s;
      end
   end

   // Pending FIFO storage and pointers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_ptr_r <= PW'(0);
         wr_ptr_r <= PW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            fifo_rd_r[i]   <= 5'd0;
            fifo_data_r[i] <= 32'd0;
         end
      end else begin
         if (enq_s) begin
            fifo_rd_r[wr_ptr_r]   <= bus.MDU_rd_in;
            fifo_data_r[wr_ptr_r] <= bus.MDU_data_in;
            wr_ptr_r              <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
      end
   end

   // Hazard lookup: an entry is live when its distance from the head is below the count.
   always_comb begin
      rs_hit_s = 1'b0;
      rt_hit_s = 1'b0;
      off_s    = PW'(0);
      for (int i = 0; i < DEPTH; i++) begin
         off_s = PW'(i) - rd_ptr_r;
         if ({1'b0, off_s} < count_r) begin
            rs_hit_s = rs_hit_s || (fifo_rd_r[i] == bus.ID_rs_in);
            rt_hit_s = rt_hit_s || (fifo_rd_r[i] == bus.ID_rt_in);
         end else begin
            rs_hit_s = rs_hit_s;
            rt_hit_s = rt_hit_s;
         end
      end
      rs_hit_s = rs_hit_s || (rf_we_r && from_mdu_r && (rf_addr_r == bus.ID_rs_in));
      rt_hit_s = rt_hit_s || (rf_we_r && from_mdu_r && (rf_addr_r == bus.ID_rt_in));
   end

   assign bus.MDU_ready_out      = ready_s;
   assign bus.RF_we_out          = rf_we_r;
   assign bus.RF_addr_out        = rf_addr_r;
   assign bus.RF_data_out        = rf_data_r;
   assign bus.ARB_stall_out      = stall_r;
   assign bus.ARB_pend_count_out = count_r;
   assign bus.ID_rs_busy_out     = (bus.ID_rs_in != 5'd0) && rs_hit_s;
   assign bus.ID_rt_busy_out     = (bus.ID_rt_in != 5'd0) && rt_hit_s;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (DEPTH=4, STARVE_MAX=8) plus hand-written
// sequences for starvation drain and reset during drain.
module tb_wb_port_arbiter;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_vec  = 0;
   int   n_err  = 0;

   wb_port_arbiter_if #(.DEPTH(4)) bus ();

   wb_port_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdata;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_stall;
      logic        e_ready;
      logic [2:0]  e_count;
      logic        e_rsb;
      logic        e_rtb;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic wb_we, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                               input logic e_stall, input logic e_ready, input logic [2:0] e_count,
                               input logic e_rsb, input logic e_rtb);
      vec_t v;
      v.wb_we = wb_we;   v.wb_addr = wb_addr; v.wb_data = wb_data;
      v.mv = mv;         v.mrd = mrd;         v.mdata = mdata;
      v.rs = rs;         v.rt = rt;
      v.e_we = e_we;     v.e_addr = e_addr;   v.e_data = e_data;
      v.e_stall = e_stall; v.e_ready = e_ready; v.e_count = e_count;
      v.e_rsb = e_rsb;   v.e_rtb = e_rtb;
      return v;
   endfunction

   task automatic drive(input logic wb_we, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                        input logic [4:0] rs, input logic [4:0] rt);
      bus.WB_ctrl_reg_write_in    = wb_we;
      bus.WB_reg_write_address_in = wb_addr;
      bus.WB_reg_write_data_in    = wb_data;
      bus.MDU_valid_in            = mv;
      bus.MDU_rd_in               = mrd;
      bus.MDU_data_in             = mdata;
      bus.ID_rs_in                = rs;
      bus.ID_rt_in                = rt;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic e_we, input logic [4:0] e_addr,
                        input logic [31:0] e_data, input logic e_stall, input logic e_ready,
                        input logic [2:0] e_count, input logic e_rsb, input logic e_rtb);
      n_vec++;
      if (bus.RF_we_out !== e_we || bus.RF_addr_out !== e_addr || bus.RF_data_out !== e_data ||
          bus.ARB_stall_out !== e_stall || bus.MDU_ready_out !== e_ready ||
          bus.ARB_pend_count_out !== e_count || bus.ID_rs_busy_out !== e_rsb ||
          bus.ID_rt_busy_out !== e_rtb) begin
         n_err++;
         $display("FAIL %s: got we=%0b addr=%0d data=%h stall=%0b ready=%0b count=%0d busy=%0b%0b, want we=%0b addr=%0d data=%h stall=%0b ready=%0b count=%0d busy=%0b%0b",
                  name, bus.RF_we_out, bus.RF_addr_out, bus.RF_data_out, bus.ARB_stall_out,
                  bus.MDU_ready_out, bus.ARB_pend_count_out, bus.ID_rs_busy_out, bus.ID_rt_busy_out,
                  e_we, e_addr, e_data, e_stall, e_ready, e_count, e_rsb, e_rtb);
      end
   endtask

   initial begin
      // WB r5, WB r0 dropped, MDU r0 dropped, MDU r7 latency and busy window
      vecs[0]  = mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0,
                    1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0,
                    1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0,
                    1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
`ifdef WB_ARB_BYPASS_EN
      vecs[3]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h42, 5'd0, 5'd7,
                    1'b1, 5'd7, 32'h42, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7,
                    1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
`else
      vecs[3]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h42, 5'd0, 5'd7,
                    1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7,
                    1'b1, 5'd7, 32'h42, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
`endif
      vecs[5]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7,
                    1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      // fill to 4 while WB holds the port, full refusal, push+pop at 3, drain across wrap
      vecs[6]  = mk(1'b1, 5'd10, 32'hA0A0, 1'b1, 5'd1, 32'h101, 5'd1, 5'd2,
                    1'b1, 5'd10, 32'hA0A0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
      vecs[7]  = mk(1'b1, 5'd11, 32'hB0B0, 1'b1, 5'd2, 32'h102, 5'd1, 5'd2,
                    1'b1, 5'd11, 32'hB0B0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
      vecs[8]  = mk(1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd3, 32'h103, 5'd3, 5'd4,
                    1'b1, 5'd12, 32'hC0C0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
      vecs[9]  = mk(1'b1, 5'd13, 32'hD0D0, 1'b1, 5'd4, 32'h104, 5'd4, 5'd5,
                    1'b1, 5'd13, 32'hD0D0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
      vecs[10] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105, 5'd5, 5'd1,
                    1'b1, 5'd1, 32'h101, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
      vecs[11] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105, 5'd5, 5'd2,
                    1'b1, 5'd2, 32'h102, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      vecs[12] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h106, 5'd6, 5'd3,
                    1'b1, 5'd3, 32'h103, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      vecs[13] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd6,
                    1'b1, 5'd4, 32'h104, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
      vecs[14] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6,
                    1'b1, 5'd5, 32'h105, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1);
      vecs[15] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6,
                    1'b1, 5'd6, 32'h106, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
      vecs[16] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd6,
                    1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);

      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      rst_in = 1'b1;
      step();
      step();
      check("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      rst_in = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].mv, vecs[i].mrd,
               vecs[i].mdata, vecs[i].rs, vecs[i].rt);
         step();
         check($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_stall,
               vecs[i].e_ready, vecs[i].e_count, vecs[i].e_rsb, vecs[i].e_rtb);
      end

      // Starvation: r3 queued, WB wins 8 times, then stalled drain, then the held WB write
      drive(1'b1, 5'd20, 32'h2000, 1'b1, 5'd3, 32'h33, 5'd0, 5'd3);
      step();
      check("starve_push", 1'b1, 5'd20, 32'h2000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 5'(20 + k), 32'h2000 + 32'(k), 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
         step();
         check($sformatf("starve_loss%0d", k), 1'b1, 5'(20 + k), 32'h2000 + 32'(k), (k == 8),
               1'b1, 3'd1, 1'b0, 1'b1);
      end
      drive(1'b1, 5'd29, 32'h2009, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
      step();
      check("drain_pop", 1'b1, 5'd3, 32'h33, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
      step();
      check("held_wb", 1'b1, 5'd29, 32'h2009, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);

      // Reach DRAIN with r8, r9, r10 pending, then reset mid-drain
      for (int k = 0; k <= 8; k++) begin
         drive(1'b1, 5'(16 + k), 32'h3000 + 32'(k), (k < 3), 5'(8 + k), 32'h800 + 32'(k), 5'd8, 5'd9);
         step();
         check($sformatf("drain_setup%0d", k), 1'b1, 5'(16 + k), 32'h3000 + 32'(k), (k == 8),
               1'b1, (k < 2) ? 3'(k + 1) : 3'd3, 1'b1, (k >= 1));
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
      rst_in = 1'b1;
      #1;
      check("rst_mid_drain", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      step();
      rst_in = 1'b0;
      step();
      check("after_rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
